// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, req/ack instruction memory
// interface, small {pc, ir} buffer towards decode, and branch redirect with stale-fetch drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic           active_r;
    logic [31:0]    fetch_pc_r;
    logic [31:0]    target_r;
    logic [31:0]    pc_mem_r [DEPTH];
    logic [31:0]    ir_mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           req_s;
    logic           ack_s;
    logic           push_s;
    logic           pop_s;
    logic [31:0]    redirect_al_s;

    assign redirect_al_s = {redirect_pc[31:2], 2'b00};
    assign ack_s         = req_s & imem_ack;
    assign push_s        = ack_s & (state_r == FETCH) & ~redirect;
    assign pop_s         = (count_r != {CW{1'b0}}) & out_ready & ~redirect;

    assign imem_req  = req_s;
    assign imem_addr = active_r ? fetch_pc_r : 32'h0000_0000;
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_pc    = pc_mem_r[rd_ptr_r];
    assign out_ir    = ir_mem_r[rd_ptr_r];

    // Request generation and next-state; a request once raised is held until acked.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            FETCH: begin
                req_s = active_r & (count_r < CW'(DEPTH));
                if (redirect && req_s && !imem_ack) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DROP: begin
                req_s = active_r;
                if (imem_ack) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: begin
                state_next_s = FETCH;
                req_s        = 1'b0;
            end
        endcase
    end

    // State register; active_r keeps imem_req low during the first cycle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= FETCH;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            active_r <= 1'b1;
        end
    end

    // Fetch PC: the old address stays on the bus in DROP, the new target waits in target_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            target_r   <= 32'h0000_0000;
        end else begin
            if (redirect) begin
                target_r <= redirect_al_s;
            end
            if (state_r == DROP) begin
                if (ack_s) begin
                    fetch_pc_r <= redirect ? redirect_al_s : target_r;
                end
            end else if (state_next_s == DROP) begin
                fetch_pc_r <= fetch_pc_r;
            end else if (redirect) begin
                fetch_pc_r <= redirect_al_s;
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
        end
    end

    // Fetch buffer; a redirect flushes it and suppresses both push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i] <= 32'h0000_0000;
                ir_mem_r[i] <= 32'h0000_0000;
            end
        end else if (redirect) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r] <= fetch_pc_r;
                ir_mem_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r           <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
